// File: rtl/config_fetch_seq.sv
// config_fetch_seq
//   Walks every neuron of the core configuration memory and, in learning time
//   steps, every neuron/axon pair. Drives the three config read ports and
//   hands the captured parameters to the neuron datapath through valid/ready.
//
// Ports
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   start_i, lrn_en_i       begin a sweep; learning mode sampled with start_i
//   busy_o, done_o          sweep in progress; one-cycle completion pulse
//   Addr/rdEn_Config_A_o    learning-parameter port (neuron address)
//   Addr/rdEn_Config_B_o    neuron-parameter port (neuron address)
//   Addr/rdEn_Config_C_o    axon learn-mode port ({neuron, axon} address)
//   nurn_idx_o, axon_idx_o  current neuron / axon
//   cfg_vld_o, cfg_rdy_i    neuron parameter handshake
//   axon_vld_o, axon_rdy_i  axon learn-mode handshake
module config_fetch_seq #(
    parameter int unsigned NUM_NURNS          = 256,
    parameter int unsigned NUM_AXONS          = 256,
    parameter int unsigned NURN_CNT_BIT_WIDTH = 8,
    parameter int unsigned AXON_CNT_BIT_WIDTH = 8
) (
    input  logic                                         clk_i,
    input  logic                                         rst_n_i,
    input  logic                                         start_i,
    input  logic                                         lrn_en_i,
    output logic                                         busy_o,
    output logic                                         done_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0]                Addr_Config_A_o,
    output logic                                         rdEn_Config_A_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0]                Addr_Config_B_o,
    output logic                                         rdEn_Config_B_o,
    output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_Config_C_o,
    output logic                                         rdEn_Config_C_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0]                nurn_idx_o,
    output logic [AXON_CNT_BIT_WIDTH-1:0]                axon_idx_o,
    output logic                                         cfg_vld_o,
    input  logic                                         cfg_rdy_i,
    output logic                                         axon_vld_o,
    input  logic                                         axon_rdy_i
);

    localparam logic [NURN_CNT_BIT_WIDTH-1:0] NURN_LAST = NURN_CNT_BIT_WIDTH'(NUM_NURNS - 1);
    localparam logic [AXON_CNT_BIT_WIDTH-1:0] AXON_LAST = AXON_CNT_BIT_WIDTH'(NUM_AXONS - 1);

    typedef enum logic [2:0] {
        IDLE,
        N_ISSUE,
        N_CAPT,
        N_PRES,
        A_ISSUE,
        A_CAPT,
        A_PRES,
        DONE
    } state_t;

    state_t                                          state, state_n;
    logic [NURN_CNT_BIT_WIDTH-1:0]                   nurn_idx, nurn_n;
    logic [AXON_CNT_BIT_WIDTH-1:0]                   axon_idx, axon_n;
    logic                                            lrn_q, lrn_n;
    logic                                            rd_a, rd_b, rd_c;
    logic [NURN_CNT_BIT_WIDTH-1:0]                   addr_a_q, addr_b_q;
    logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] addr_c_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            nurn_idx <= '0;
            axon_idx <= '0;
            lrn_q    <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
        end else begin
            state    <= state_n;
            nurn_idx <= nurn_n;
            axon_idx <= axon_n;
            lrn_q    <= lrn_n;
            // Remember the last driven address so the ports hold it once the
            // read enables drop.
            if (rd_a) addr_a_q <= nurn_idx;
            if (rd_b) addr_b_q <= nurn_idx;
            if (rd_c) addr_c_q <= {nurn_idx, axon_idx};
        end
    end

    always_comb begin
        state_n   = state;
        nurn_n    = nurn_idx;
        axon_n    = axon_idx;
        lrn_n     = lrn_q;
        rd_a      = 1'b0;
        rd_b      = 1'b0;
        rd_c      = 1'b0;
        cfg_vld_o  = 1'b0;
        axon_vld_o = 1'b0;
        done_o     = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    lrn_n   = lrn_en_i;
                    nurn_n  = '0;
                    axon_n  = '0;
                    state_n = N_ISSUE;
                end
            end
            N_ISSUE: begin
                rd_b    = 1'b1;
                rd_a    = lrn_q;
                state_n = N_CAPT;
            end
            N_CAPT: begin
                rd_b    = 1'b1;
                rd_a    = lrn_q;
                state_n = N_PRES;
            end
            N_PRES: begin
                cfg_vld_o = 1'b1;
                if (cfg_rdy_i) begin
                    if (lrn_q) begin
                        axon_n  = '0;
                        state_n = A_ISSUE;
                    end else if (nurn_idx == NURN_LAST) begin
                        state_n = DONE;
                    end else begin
                        nurn_n  = nurn_idx + 1'b1;
                        state_n = N_ISSUE;
                    end
                end
            end
            A_ISSUE: begin
                rd_c    = 1'b1;
                state_n = A_CAPT;
            end
            A_CAPT: begin
                rd_c    = 1'b1;
                state_n = A_PRES;
            end
            A_PRES: begin
                axon_vld_o = 1'b1;
                if (axon_rdy_i) begin
                    if (axon_idx != AXON_LAST) begin
                        axon_n  = axon_idx + 1'b1;
                        state_n = A_ISSUE;
                    end else if (nurn_idx == NURN_LAST) begin
                        state_n = DONE;
                    end else begin
                        nurn_n  = nurn_idx + 1'b1;
                        axon_n  = '0;
                        state_n = N_ISSUE;
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy_o          = (state != IDLE);
    assign rdEn_Config_A_o = rd_a;
    assign rdEn_Config_B_o = rd_b;
    assign rdEn_Config_C_o = rd_c;
    assign Addr_Config_A_o = rd_a ? nurn_idx : addr_a_q;
    assign Addr_Config_B_o = rd_b ? nurn_idx : addr_b_q;
    assign Addr_Config_C_o = rd_c ? {nurn_idx, axon_idx} : addr_c_q;
    assign nurn_idx_o      = nurn_idx;
    assign axon_idx_o      = axon_idx;

endmodule

// File: tb/tb_config_fetch_seq.sv
module tb_config_fetch_seq;

    localparam int unsigned NN = 4;
    localparam int unsigned NA = 2;

    // Expected control vector bits: {busy, done, rdA, rdB, rdC, cfg_vld, axon_vld}
    localparam logic [6:0] C_BUSY = 7'b1000000;
    localparam logic [6:0] C_DN   = 7'b0100000;
    localparam logic [6:0] C_RA   = 7'b0010000;
    localparam logic [6:0] C_RB   = 7'b0001000;
    localparam logic [6:0] C_RC   = 7'b0000100;
    localparam logic [6:0] C_CV   = 7'b0000010;
    localparam logic [6:0] C_AV   = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst_n, start, lrn_en, cfg_rdy, axon_rdy;
    logic        busy, done, rd_a, rd_b, rd_c, cfg_vld, axon_vld;
    logic [7:0]  addr_a, addr_b, nurn_idx, axon_idx;
    logic [15:0] addr_c;

    always #5 clk = ~clk;

    config_fetch_seq #(
        .NUM_NURNS(NN),
        .NUM_AXONS(NA),
        .NURN_CNT_BIT_WIDTH(8),
        .AXON_CNT_BIT_WIDTH(8)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .start_i(start),
        .lrn_en_i(lrn_en),
        .busy_o(busy),
        .done_o(done),
        .Addr_Config_A_o(addr_a),
        .rdEn_Config_A_o(rd_a),
        .Addr_Config_B_o(addr_b),
        .rdEn_Config_B_o(rd_b),
        .Addr_Config_C_o(addr_c),
        .rdEn_Config_C_o(rd_c),
        .nurn_idx_o(nurn_idx),
        .axon_idx_o(axon_idx),
        .cfg_vld_o(cfg_vld),
        .cfg_rdy_i(cfg_rdy),
        .axon_vld_o(axon_vld),
        .axon_rdy_i(axon_rdy)
    );

    typedef struct {
        logic [6:0]  ctl;
        logic [7:0]  addr_a;
        logic [7:0]  addr_b;
        logic [15:0] addr_c;
        logic [7:0]  ni;
        logic [7:0]  ai;
        logic        crdy;
        logic        ardy;
    } rec_t;

    rec_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;

    // Model of the externally visible "held" values across sweeps.
    logic [7:0]  m_ha, m_hb, m_ni, m_ai;
    logic [15:0] m_hc;

    int unsigned stall_n[NN];
    int unsigned stall_a[NN][NA];

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void model_reset();
        m_ha = '0; m_hb = '0; m_hc = '0; m_ni = '0; m_ai = '0;
    endfunction

    function automatic void clear_stalls();
        for (int n = 0; n < NN; n++) begin
            stall_n[n] = 0;
            for (int a = 0; a < NA; a++) stall_a[n][a] = 0;
        end
    endfunction

    function automatic void push(input logic [6:0] ctl, input logic crdy, input logic ardy);
        rec_t r;
        r.ctl = ctl; r.addr_a = m_ha; r.addr_b = m_hb; r.addr_c = m_hc;
        r.ni = m_ni; r.ai = m_ai; r.crdy = crdy; r.ardy = ardy;
        exp_q.push_back(r);
    endfunction

    // Per-cycle expected transcript of one sweep: each read is two enable
    // cycles, then valid held through the stall cycles plus the handshake cycle.
    function automatic void build(input logic lrn);
        exp_q.delete();
        for (int n = 0; n < NN; n++) begin
            m_ni = 8'(n);
            m_ai = '0;
            m_hb = 8'(n);
            if (lrn) m_ha = 8'(n);
            repeat (2) push(C_BUSY | C_RB | (lrn ? C_RA : 7'b0), rb(), rb());
            for (int k = 0; k < int'(stall_n[n]); k++) push(C_BUSY | C_CV, 1'b0, rb());
            push(C_BUSY | C_CV, 1'b1, rb());
            if (lrn) begin
                for (int a = 0; a < NA; a++) begin
                    m_ai = 8'(a);
                    m_hc = {8'(n), 8'(a)};
                    repeat (2) push(C_BUSY | C_RC, rb(), rb());
                    for (int k = 0; k < int'(stall_a[n][a]); k++) push(C_BUSY | C_AV, rb(), 1'b0);
                    push(C_BUSY | C_AV, rb(), 1'b1);
                end
            end
        end
        push(C_BUSY | C_DN, rb(), rb());
    endfunction

    // Runs one sweep from idle against the transcript; returns the cycle
    // (start edge = cycle 0) in which done_o was observed, or 0 if never.
    task automatic sweep_scenario(input logic lrn, input bit glitch, input string tag,
                                  output int done_cyc);
        build(lrn);
        done_cyc = 0;
        lrn_en = lrn;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            cfg_rdy  = exp_q[i].crdy;
            axon_rdy = exp_q[i].ardy;
            if (glitch) begin
                start  = rb();
                lrn_en = rb();
            end
            @(negedge clk);
            if (done === 1'b1 && done_cyc == 0) done_cyc = i + 1;
            checks++;
            if ({busy, done, rd_a, rd_b, rd_c, cfg_vld, axon_vld} !== exp_q[i].ctl) begin
                errors++;
                $display("FAIL %s ctl cycle %0d: got %b want %b", tag, i + 1,
                         {busy, done, rd_a, rd_b, rd_c, cfg_vld, axon_vld}, exp_q[i].ctl);
            end
            checks++;
            if ({addr_a, addr_b, addr_c} !== {exp_q[i].addr_a, exp_q[i].addr_b, exp_q[i].addr_c}) begin
                errors++;
                $display("FAIL %s addr cycle %0d: got A=%h B=%h C=%h want A=%h B=%h C=%h", tag, i + 1,
                         addr_a, addr_b, addr_c, exp_q[i].addr_a, exp_q[i].addr_b, exp_q[i].addr_c);
            end
            checks++;
            if ({nurn_idx, axon_idx} !== {exp_q[i].ni, exp_q[i].ai}) begin
                errors++;
                $display("FAIL %s idx cycle %0d: got n=%0d a=%0d want n=%0d a=%0d", tag, i + 1,
                         nurn_idx, axon_idx, exp_q[i].ni, exp_q[i].ai);
            end
            @(posedge clk); #1;
        end
        start = 1'b0; cfg_rdy = 1'b0; axon_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, rd_a, rd_b, rd_c, cfg_vld, axon_vld} !== 7'b0) begin
            errors++;
            $display("FAIL %s idle_ctl: got %b want 0000000", tag,
                     {busy, done, rd_a, rd_b, rd_c, cfg_vld, axon_vld});
        end
        checks++;
        if ({addr_a, addr_b, addr_c, nurn_idx, axon_idx} !== {m_ha, m_hb, m_hc, m_ni, m_ai}) begin
            errors++;
            $display("FAIL %s idle_hold: got A=%h B=%h C=%h n=%0d a=%0d want A=%h B=%h C=%h n=%0d a=%0d",
                     tag, addr_a, addr_b, addr_c, nurn_idx, axon_idx, m_ha, m_hb, m_hc, m_ni, m_ai);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; lrn_en = 1'b0; cfg_rdy = 1'b0; axon_rdy = 1'b0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({busy, done, rd_a, rd_b, rd_c, cfg_vld, axon_vld, addr_a, addr_b, addr_c, nurn_idx, axon_idx} !== 55'd0) begin
                errors++;
                $display("FAIL reset_values: got busy=%b done=%b rd=%b%b%b vld=%b%b A=%h B=%h C=%h n=%0d a=%0d want all 0",
                         busy, done, rd_a, rd_b, rd_c, cfg_vld, axon_vld, addr_a, addr_b, addr_c, nurn_idx, axon_idx);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({busy, done, rd_a, rd_b, rd_c, cfg_vld, axon_vld, addr_a, addr_b, addr_c, nurn_idx, axon_idx} !== 55'd0) begin
                errors++;
                $display("FAIL idle_no_start: got busy=%b done=%b rd=%b%b%b vld=%b%b A=%h B=%h C=%h want all 0",
                         busy, done, rd_a, rd_b, rd_c, cfg_vld, axon_vld, addr_a, addr_b, addr_c);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_no_learn();
        int dc;
        clear_stalls();
        sweep_scenario(1'b0, 1'b0, "no_learn", dc);
        checks++;
        if (dc !== 13) begin
            errors++;
            $display("FAIL no_learn_done_cycle: got %0d want 13", dc);
        end
    endtask

    task automatic test_back_pressure();
        int dc;
        clear_stalls();
        stall_n[2] = 5;
        sweep_scenario(1'b0, 1'b0, "bp_cfg", dc);
        checks++;
        if (dc !== 18) begin
            errors++;
            $display("FAIL bp_cfg_done_cycle: got %0d want 18", dc);
        end
        clear_stalls();
        stall_a[2][1] = 5;
        sweep_scenario(1'b1, 1'b0, "bp_axon", dc);
        checks++;
        if (dc !== 42) begin
            errors++;
            $display("FAIL bp_axon_done_cycle: got %0d want 42", dc);
        end
    endtask

    task automatic test_learn();
        int dc;
        clear_stalls();
        sweep_scenario(1'b1, 1'b0, "learn", dc);
        checks++;
        if (dc !== 37) begin
            errors++;
            $display("FAIL learn_done_cycle: got %0d want 37", dc);
        end
    endtask

    // Random stalls plus random start_i / lrn_en_i activity throughout.
    task automatic test_start_while_busy();
        int dc;
        int unsigned want;
        for (int rep = 0; rep < 4; rep++) begin
            logic lrn;
            lrn = 1'(rep % 2);
            clear_stalls();
            want = lrn ? NN * (3 + 3 * NA) + 1 : 3 * NN + 1;
            for (int n = 0; n < NN; n++) begin
                stall_n[n] = $urandom_range(0, 2);
                want += stall_n[n];
                if (lrn) begin
                    for (int a = 0; a < NA; a++) begin
                        stall_a[n][a] = $urandom_range(0, 2);
                        want += stall_a[n][a];
                    end
                end
            end
            sweep_scenario(lrn, 1'b1, "busy_start", dc);
            checks++;
            if (dc !== int'(want)) begin
                errors++;
                $display("FAIL busy_start_len rep %0d: got %0d want %0d", rep, dc, want);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int dc;
        clear_stalls();
        cfg_rdy = 1'b1; axon_rdy = 1'b1; lrn_en = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        // Cycle 5: second port-C read cycle of neuron 0, axon 0.
        checks++;
        if ({rd_c, axon_vld, addr_c} !== {1'b1, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL pre_reset_a_capt: got rdC=%b avld=%b C=%h want rdC=1 avld=0 C=0000",
                     rd_c, axon_vld, addr_c);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, rd_a, rd_b, rd_c, cfg_vld, axon_vld, addr_a, addr_b, addr_c, nurn_idx, axon_idx} !== 55'd0) begin
            errors++;
            $display("FAIL reset_async: got busy=%b done=%b rd=%b%b%b vld=%b%b A=%h B=%h C=%h n=%0d a=%0d want all 0",
                     busy, done, rd_a, rd_b, rd_c, cfg_vld, axon_vld, addr_a, addr_b, addr_c, nurn_idx, axon_idx);
        end
        model_reset();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({busy, done, rd_a, rd_b, rd_c, cfg_vld, axon_vld} !== 7'b0) begin
                errors++;
                $display("FAIL reset_hold: got %b want 0000000", {busy, done, rd_a, rd_b, rd_c, cfg_vld, axon_vld});
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        cfg_rdy = 1'b0; axon_rdy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({busy, done, rd_a, rd_b, rd_c, cfg_vld, axon_vld, addr_a, addr_b, addr_c, nurn_idx, axon_idx} !== 55'd0) begin
                errors++;
                $display("FAIL post_reset_idle: got busy=%b done=%b A=%h B=%h C=%h n=%0d want all 0",
                         busy, done, addr_a, addr_b, addr_c, nurn_idx);
            end
        end
        @(posedge clk); #1;
        sweep_scenario(1'b1, 1'b0, "restart", dc);
        checks++;
        if (dc !== 37) begin
            errors++;
            $display("FAIL restart_done_cycle: got %0d want 37", dc);
        end
    endtask

    initial begin
        test_reset();
        test_no_learn();
        test_back_pressure();
        test_learn();
        test_no_learn();
        test_start_while_busy();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/config_fetch_seq.md
# config_fetch_seq

Sequencer that walks every neuron (and, in learning time steps, every neuron/axon pair) of the core's configuration memory, driving the three config read ports and presenting the captured parameters to the neuron datapath via valid/ready handshakes. It sits between the time-step controller, which issues `start_i`, and the config memory plus neuron update/learning units. It owns all `Addr_Config_*`/`rdEn_Config_*` signals, so no other block drives those ports.

## Interface
- NUM_NURNS, 256, neurons per core; index range 0..NUM_NURNS-1
- NUM_AXONS, 256, axons per neuron; index range 0..NUM_AXONS-1
- NURN_CNT_BIT_WIDTH, 8, neuron index width
- AXON_CNT_BIT_WIDTH, 8, axon index width

- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle pulse, begin a time-step sweep
- lrn_en_i  in  1  learning enable, sampled with start_i
- busy_o  out  1  sweep in progress
- done_o  out  1  one-cycle pulse, sweep complete
- Addr_Config_A_o  out  NURN_CNT_BIT_WIDTH  port A address (learning params)
- rdEn_Config_A_o  out  1  port A read/latch enable
- Addr_Config_B_o  out  NURN_CNT_BIT_WIDTH  port B address (neuron params)
- rdEn_Config_B_o  out  1  port B read/latch enable
- Addr_Config_C_o  out  NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH  port C address, {nurn_idx, axon_idx}
- rdEn_Config_C_o  out  1  port C read/latch enable
- nurn_idx_o  out  NURN_CNT_BIT_WIDTH  current neuron
- axon_idx_o  out  AXON_CNT_BIT_WIDTH  current axon
- cfg_vld_o  out  1  port B (and A if learning) outputs valid for nurn_idx_o
- cfg_rdy_i  in  1  datapath accepts neuron params
- axon_vld_o  out  1  port C output valid for {nurn_idx_o, axon_idx_o}
- axon_rdy_i  in  1  learning unit accepts axon learn mode

## Operation
- States: IDLE, N_ISSUE, N_CAPT, N_PRES, A_ISSUE, A_CAPT, A_PRES, DONE.
- IDLE: start_i=1 → latch lrn_q=lrn_en_i, nurn_idx=0, axon_idx=0, go N_ISSUE. start_i is ignored in every other state.
- N_ISSUE, N_CAPT: drive Addr_B=nurn_idx with rdEn_B=1. When lrn_q=1, also drive Addr_A=nurn_idx with rdEn_A=1. Addresses are held constant across both cycles. The ROM registers the address in N_ISSUE; its q is valid in N_CAPT, where the transparent latch captures it.
- N_PRES: all rdEn low (latches hold), cfg_vld_o=1. Stay until cfg_rdy_i=1. On handshake:
  - lrn_q=1 → A_ISSUE, axon_idx=0.
  - else, nurn_idx is last → DONE.
  - else → nurn_idx+1, N_ISSUE.
- A_ISSUE, A_CAPT: Addr_C={nurn_idx,axon_idx}, rdEn_C=1, both cycles.
- A_PRES: axon_vld_o=1. Stay until axon_rdy_i=1. On handshake:
  - axon_idx < NUM_AXONS-1 → axon_idx+1, A_ISSUE.
  - else, nurn_idx is last → DONE.
  - else → nurn_idx+1, axon_idx=0, N_ISSUE.
- DONE: done_o=1 for one cycle → IDLE.
- busy_o=1 in every state except IDLE.
- Idle address values: in non-driving states, Addr_* hold the last driven value and rdEn_* are 0.
- Index counters compare against NUM_NURNS-1 and NUM_AXONS-1, never against all-ones, and never wrap. Non-power-of-two counts are legal.
- Reset (any state, mid-sweep included): state=IDLE. All outputs are 0, all counters are 0, lrn_q=0. No done_o is emitted for an aborted sweep.

## Timing
- start_i sampled at edge 0 → N_ISSUE in cycle 1, cfg_vld_o first high in cycle 3.
- Every read: exactly 2 cycles of rdEn=1 with a stable address, then valid from the 3rd cycle.
- Valid stays high, and indices, addresses and latched data stay stable, while ready is low. Valid drops the cycle after the handshake.
- Sweep length with ready tied high:
  - no learning: 3·NUM_NURNS cycles, then 1 DONE cycle.
  - learning: NUM_NURNS·(3+3·NUM_AXONS) cycles, then 1 DONE cycle.
- cfg_vld_o and axon_vld_o are never high together.
- rdEn_A/B are never high in the same cycle as rdEn_C.

## Test plan
- Reset values: assert rst_n_i → every output 0, busy_o=0. Release, with no start_i → outputs stay 0.
- No-learn sweep: NUM_NURNS=4, rdy high, start_i at cycle 0 → rdEn_B high in cycles 1-2, 4-5, 7-8, 10-11. rdEn_A and rdEn_C never high. cfg_vld_o in cycles 3, 6, 9, 12 with nurn_idx 0-3. done_o in cycle 13, busy_o low from cycle 14.
- Learn sweep: NUM_NURNS=4, NUM_AXONS=2, lrn_en_i=1 → Addr_C sequence 0x000, 0x001, 0x100, 0x101, … 0x301. done_o in cycle 37. rdEn_A coincides with rdEn_B.
- Back-pressure: hold cfg_rdy_i low 5 cycles at neuron 2 → cfg_vld_o high 6 cycles, Addr_B=2 stable, all rdEn low, then proceeds to neuron 3. Repeat with axon_rdy_i on axon 1.
- Start while busy: pulse start_i mid-sweep → ignored, sweep length unchanged. Toggling lrn_en_i mid-sweep has no effect.
- Reset mid-sweep: assert rst_n_i during A_CAPT → all outputs 0 immediately, no done_o. A new start_i restarts from neuron 0.
